// File: rtl/quad_decoder.sv
// quad_decoder: quadrature encoder front end for the up/down/load counter.
// Synchronises the raw A/B (and optional index) channels, debounces each one,
// then decodes accepted A/B transitions into one-cycle up/down strobes.
// A simultaneous change of both A and B sets a sticky err flag.
//
// Parameters:
//   n      - width of the in output (matches the counter width)
//   DB     - debounce length in cycles, 1..255
//   PRESET - value driven on in when the index feature is built
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   a, b - asynchronous encoder channels
//   idx  - asynchronous encoder index (used only with QDEC_INDEX_EN)
//   up   - one-cycle forward-step strobe
//   down - one-cycle reverse-step strobe
//   load - one-cycle index-load strobe
//   in   - counter load value
//   err  - sticky illegal-transition flag
//
// Build option: define QDEC_INDEX_EN to build the index channel and load logic.
module quad_decoder #(
    parameter int unsigned    n      = 4,
    parameter int unsigned    DB     = 4,
    parameter logic [n-1:0]   PRESET = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a,
    input  logic         b,
    input  logic         idx,
    output logic         up,
    output logic         down,
    output logic         load,
    output logic [n-1:0] in,
    output logic         err
);

    // Channel bit order: 0 = A, 1 = B, 2 = index (when built).
`ifdef QDEC_INDEX_EN
    localparam int unsigned NCH = 3;
`else
    localparam int unsigned NCH = 2;
`endif

    typedef enum logic {INIT, RUN} state_t;

    state_t         state;
    logic [1:0]     init_cnt;
    logic [NCH-1:0] raw;
    logic [NCH-1:0] meta;
    logic [NCH-1:0] sync;
    logic [NCH-1:0] acc;
    logic [NCH-1:0] prev;
    logic [7:0]     cnt [NCH];

    logic [1:0]     old_p;
    logic [1:0]     new_p;
    logic           step_up;
    logic           step_dn;
    logic           step_bad;
    logic           idx_rise;

`ifdef QDEC_INDEX_EN
    assign raw = {idx, b, a};
    assign in  = PRESET;
`else
    assign raw = {b, a};
    assign in  = '0;
    logic unused;
    assign unused = ^{idx, PRESET};
`endif

    // Position of {A,B} along the forward Gray sequence 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] pos(input logic ach, input logic bch);
        case ({ach, bch})
            2'b00:   pos = 2'd0;
            2'b10:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
    endfunction

    // prev holds the accepted value from the previous cycle, so any change
    // of the accepted A/B shows up as prev != acc for exactly one cycle.
    always_comb begin
        old_p    = pos(prev[0], prev[1]);
        new_p    = pos(acc[0], acc[1]);
        step_up  = (new_p == old_p + 2'd1);
        step_dn  = (new_p == old_p - 2'd1);
        step_bad = (acc[1:0] == ~prev[1:0]);
`ifdef QDEC_INDEX_EN
        idx_rise = acc[2] & ~prev[2];
`else
        idx_rise = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
            meta     <= '0;
            sync     <= '0;
            acc      <= '0;
            prev     <= '0;
            for (int unsigned ch = 0; ch < NCH; ch++) cnt[ch] <= '0;
            up       <= 1'b0;
            down     <= 1'b0;
            load     <= 1'b0;
            err      <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            up   <= 1'b0;
            down <= 1'b0;
            load <= 1'b0;
            case (state)
                INIT: begin
                    // Track the inputs directly so RUN starts from the
                    // encoder's resting position without a spurious step.
                    acc  <= sync;
                    prev <= sync;
                    for (int unsigned ch = 0; ch < NCH; ch++) cnt[ch] <= '0;
                    init_cnt <= init_cnt + 2'd1;
                    if (init_cnt == 2'd2) state <= RUN;
                end
                RUN: begin
                    for (int unsigned ch = 0; ch < NCH; ch++) begin
                        if (sync[ch] == acc[ch]) begin
                            cnt[ch] <= '0;
                        end else if (cnt[ch] == 8'(DB - 1)) begin
                            acc[ch] <= sync[ch];
                            cnt[ch] <= '0;
                        end else begin
                            cnt[ch] <= cnt[ch] + 8'd1;
                        end
                    end
                    prev <= acc;
                    if (step_bad) err <= 1'b1;
                    // Load has priority over a coincident step; the step is dropped.
                    if (idx_rise) begin
                        load <= 1'b1;
                    end else begin
                        up   <= step_up;
                        down <= step_dn;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder: table of encoder states with expected strobe
// counts and positions, plus hand-written reset and index sequences.
module tb_quad_decoder;

    localparam int DBV = 4;
`ifdef QDEC_INDEX_EN
    localparam logic [3:0] EXP_IN = 4'hA;
`else
    localparam logic [3:0] EXP_IN = 4'h0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a   = 1'b0;
    logic       b   = 1'b0;
    logic       idx = 1'b0;
    logic       up;
    logic       down;
    logic       load;
    logic [3:0] in;
    logic       err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    quad_decoder #(.n(4), .DB(DBV), .PRESET(4'hA)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .idx  (idx),
        .up   (up),
        .down (down),
        .load (load),
        .in   (in),
        .err  (err)
    );

    typedef struct {
        logic a;
        logic b;
        int   hold;
        int   nup;
        int   ndn;
        int   upat;
        int   dnat;
        logic err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Run for hold cycles sampling 1 time unit after each rising edge.
    // *at = 1-based tick index of the first pulse, 0 if none.
    task automatic watch(input int hold, output int nup, output int ndn,
                         output int nld, output int upat, output int dnat,
                         output int ldat, output int both);
        nup = 0; ndn = 0; nld = 0; upat = 0; dnat = 0; ldat = 0; both = 0;
        for (int t = 1; t <= hold; t++) begin
            @(posedge clk); #1;
            if (up)   begin nup++; if (upat == 0) upat = t; end
            if (down) begin ndn++; if (dnat == 0) dnat = t; end
            if (load) begin nld++; if (ldat == 0) ldat = t; end
            if (up && down) both++;
        end
    endtask

    initial begin
        int nup, ndn, nld, upat, dnat, ldat, both;

        //          a     b     hold up dn upat dnat err
        tbl[0]  = '{1'b1, 1'b0, 8,  1, 0, 7, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8,  1, 0, 7, 0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8,  1, 0, 7, 0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8,  1, 0, 7, 0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8,  0, 1, 0, 7, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 8,  0, 1, 0, 7, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8,  0, 1, 0, 7, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8,  0, 1, 0, 7, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3,  0, 0, 0, 0, 1'b0};  // 3-cycle glitch
        tbl[9]  = '{1'b0, 1'b0, 10, 0, 0, 0, 0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 4,  0, 0, 0, 0, 1'b0};  // 4-cycle pulse
        tbl[11] = '{1'b0, 1'b0, 12, 1, 1, 3, 7, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 10, 0, 0, 0, 0, 1'b1};  // illegal 00->11

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_up",   up,   0);
        chk("rst_down", down, 0);
        chk("rst_load", load, 0);
        chk("rst_err",  err,  0);
        chk("rst_in",   in,   EXP_IN);

        // Idle at 00 for 10 cycles after reset
        rst = 1'b0;
        watch(10, nup, ndn, nld, upat, dnat, ldat, both);
        chk("idle_up",   nup, 0);
        chk("idle_down", ndn, 0);
        chk("idle_load", nld, 0);
        chk("idle_err",  err, 0);
        chk("idle_in",   in,  EXP_IN);

        // Table: strobe at tick DB+3 from drive (= DB+2 edges after first sample)
        for (int i = 0; i < 13; i++) begin
            a = tbl[i].a;
            b = tbl[i].b;
            watch(tbl[i].hold, nup, ndn, nld, upat, dnat, ldat, both);
            chk($sformatf("v%0d_nup", i),  nup,  tbl[i].nup);
            chk($sformatf("v%0d_ndn", i),  ndn,  tbl[i].ndn);
            chk($sformatf("v%0d_upat", i), upat, tbl[i].upat);
            chk($sformatf("v%0d_dnat", i), dnat, tbl[i].dnat);
            chk($sformatf("v%0d_load", i), nld,  0);
            chk($sformatf("v%0d_both", i), both, 0);
            chk($sformatf("v%0d_err", i),  err,  tbl[i].err);
        end

        // err is sticky until reset
        watch(10, nup, ndn, nld, upat, dnat, ldat, both);
        chk("err_sticky", err, 1);
        a = 1'b0; b = 1'b0;
        rst = 1'b1;
        watch(2, nup, ndn, nld, upat, dnat, ldat, both);
        chk("err_cleared", err, 0);
        rst = 1'b0;
        watch(12, nup, ndn, nld, upat, dnat, ldat, both);
        chk("post_rst_up",   nup, 0);
        chk("post_rst_down", ndn, 0);
        chk("post_rst_err",  err, 0);

        // Reset two cycles after an A edge drops the pending step
        a = 1'b1;
        watch(2, nup, ndn, nld, upat, dnat, ldat, both);
        rst = 1'b1;
        watch(2, nup, ndn, nld, upat, dnat, ldat, both);
        rst = 1'b0;
        watch(15, nup, ndn, nld, upat, dnat, ldat, both);
        chk("midstep_up",   nup, 0);
        chk("midstep_down", ndn, 0);
        chk("midstep_err",  err, 0);
        b = 1'b1;   // 10 -> 11 forward
        watch(8, nup, ndn, nld, upat, dnat, ldat, both);
        chk("after_mid_nup",  nup,  1);
        chk("after_mid_upat", upat, 7);
        chk("after_mid_ndn",  ndn,  0);

        // Encoder resting at 11 through INIT
        rst = 1'b1;
        watch(2, nup, ndn, nld, upat, dnat, ldat, both);
        rst = 1'b0;
        watch(12, nup, ndn, nld, upat, dnat, ldat, both);
        chk("rest11_up",   nup, 0);
        chk("rest11_down", ndn, 0);
        chk("rest11_err",  err, 0);
        a = 1'b0;   // 11 -> 01 forward
        watch(8, nup, ndn, nld, upat, dnat, ldat, both);
        chk("rest11_step_nup",  nup,  1);
        chk("rest11_step_upat", upat, 7);
        chk("rest11_step_err",  err,  0);

`ifdef QDEC_INDEX_EN
        // Index pulse -> one load with in = PRESET
        idx = 1'b1;
        watch(8, nup, ndn, nld, upat, dnat, ldat, both);
        chk("idx_nld",  nld,  1);
        chk("idx_ldat", ldat, 7);
        chk("idx_in",   in,   4'hA);
        chk("idx_nup",  nup,  0);
        idx = 1'b0;
        watch(10, nup, ndn, nld, upat, dnat, ldat, both);
        chk("idx_fall_nld", nld, 0);
        // Index coincident with a step (01 -> 00 forward): load wins
        idx = 1'b1;
        b   = 1'b0;
        watch(10, nup, ndn, nld, upat, dnat, ldat, both);
        chk("coin_nld",  nld,  1);
        chk("coin_ldat", ldat, 7);
        chk("coin_nup",  nup,  0);
        chk("coin_ndn",  ndn,  0);
        chk("coin_err",  err,  0);
`else
        // Index ignored when the feature is not built
        idx = 1'b1;
        watch(10, nup, ndn, nld, upat, dnat, ldat, both);
        chk("noidx_nld", nld, 0);
        chk("noidx_in",  in,  4'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
